// File: rtl/mips_pkg.sv
// Shared MIPS definitions: datapath widths and the fixed boot program
// held in the instruction ROM.
package mips_pkg;

  localparam int INSTR_WIDTH     = 32;
  localparam int IMEM_ADDR_WIDTH = 10;

  localparam logic [INSTR_WIDTH-1:0] NOP = 32'h0000_0000;

  localparam logic [INSTR_WIDTH-1:0] BOOT_ADDI_T0 = 32'h2008_0005; // addi $t0,$zero,5
  localparam logic [INSTR_WIDTH-1:0] BOOT_ADDI_T1 = 32'h2009_000A; // addi $t1,$zero,10
  localparam logic [INSTR_WIDTH-1:0] BOOT_ADD_T2  = 32'h0109_5020;
  localparam logic [INSTR_WIDTH-1:0] BOOT_SUB_T3  = 32'h0128_5822;
  localparam logic [INSTR_WIDTH-1:0] BOOT_AND_T4  = 32'h0109_6024;
  localparam logic [INSTR_WIDTH-1:0] BOOT_OR_T5   = 32'h0109_6825;
  localparam logic [INSTR_WIDTH-1:0] BOOT_SLT_T6  = 32'h0109_702A;
  localparam logic [INSTR_WIDTH-1:0] BOOT_SW_T2   = 32'hAC0A_0000;
  localparam logic [INSTR_WIDTH-1:0] BOOT_LW_T7   = 32'h8C0F_0000;
  localparam logic [INSTR_WIDTH-1:0] BOOT_HALT    = 32'h1108_FFFF; // beq $t0,$t0,-1

  // Everything past the boot program decodes to NOP.
  function automatic logic [INSTR_WIDTH-1:0] boot_word(input int unsigned idx);
    logic [INSTR_WIDTH-1:0] w;
    w = NOP;
    case (idx)
      0:       w = BOOT_ADDI_T0;
      1:       w = BOOT_ADDI_T1;
      2:       w = BOOT_ADD_T2;
      3:       w = BOOT_SUB_T3;
      4:       w = BOOT_AND_T4;
      5:       w = BOOT_OR_T5;
      6:       w = BOOT_SLT_T6;
      7:       w = BOOT_SW_T2;
      8:       w = BOOT_LW_T7;
      9:       w = BOOT_HALT;
      default: w = NOP;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Read-only program store for the MIPS fetch stage: word-addressed
// synchronous ROM with a registered output that reset clears.
module instruction_memory
  import mips_pkg::*;
#(
  parameter int data_WIDTH = INSTR_WIDTH,
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [data_WIDTH-1:0] dataOut
);

  logic [data_WIDTH-1:0] rom_word;

  always_comb begin
    rom_word = data_WIDTH'(boot_word(int'(address)));
  end

  // Reset clears only the output register; the ROM contents are constant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut <= '0;
    end else begin
      dataOut <= rom_word;
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: scoreboard of expected words
// pushed on each applied address and popped one edge later.
module tb_instruction_memory;

  localparam int W  = 32;
  localparam int AW = 10;

  logic          clk;
  logic          clk_en;
  logic          reset;
  logic [AW-1:0] address;
  logic [W-1:0]  dataOut;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] prog [0:9];
  int vectors;
  int miscompares;

  instruction_memory #(.data_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .dataOut (dataOut)
  );

  // clock / reset block: 100 ns period, gateable for the stopped-clock check
  initial clk = 1'b0;
  always begin
    #50;
    if (clk_en) clk = ~clk;
  end

  function automatic logic [W-1:0] model(input int a);
    if (a < 10) return prog[a];
    return '0;
  endfunction

  // drive one address at the falling edge, then compare one edge later
  task automatic read(input int a, input string name);
    logic [W-1:0] exp;
    @(negedge clk);
    address = AW'(a);
    exp_q.push_back(model(a));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (dataOut !== exp) begin
      miscompares++;
      $display("FAIL %s addr=%0d got=%h expected=%h", name, a, dataOut, exp);
    end
  endtask

  task automatic check_now(input logic [W-1:0] exp, input string name);
    vectors++;
    if (dataOut !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, dataOut, exp);
    end
  endtask

  task automatic test_reset();
    #10;
    reset = 1'b1;
    #1;
    check_now(32'h0000_0000, "reset_no_clock");
    #20;
    reset = 1'b0;
    #5;
    check_now(32'h0000_0000, "reset_released_hold");
    clk_en = 1'b1;
    read(0, "first_read_after_reset");
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 10; i++) read(i, "sequential_fetch");
  endtask

  task automatic test_hold();
    read(2, "hold_initial");
    #20;
    address = AW'(3);
    #10;
    check_now(32'h0109_5020, "hold_mid_cycle");
    exp_q.push_back(model(3));
    @(posedge clk);
    #1;
    vectors++;
    if (dataOut !== exp_q[0]) begin
      miscompares++;
      $display("FAIL hold_next_edge got=%h expected=%h", dataOut, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_unpopulated();
    read(10, "unpopulated_10");
    read(512, "unpopulated_512");
    read(1023, "unpopulated_1023");
    read(5, "after_unpopulated");
    read(int'($urandom_range(11, 1022)), "unpopulated_random");
  endtask

  task automatic test_reset_midstream();
    read(5, "midstream_before_reset");
    #10;
    reset = 1'b1;
    #1;
    check_now(32'h0000_0000, "midstream_async_clear");
    #5;
    reset = 1'b0;
    #1;
    check_now(32'h0000_0000, "midstream_release_hold");
    read(6, "midstream_after_release");
  endtask

  task automatic test_repeat();
    for (int i = 0; i < 5; i++) read(9, "repeat_halt");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) read(int'($urandom_range(0, 15)), "random_read");
  endtask

  initial begin
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_000A;
    prog[2] = 32'h0109_5020;
    prog[3] = 32'h0128_5822;
    prog[4] = 32'h0109_6024;
    prog[5] = 32'h0109_6825;
    prog[6] = 32'h0109_702A;
    prog[7] = 32'hAC0A_0000;
    prog[8] = 32'h8C0F_0000;
    prog[9] = 32'h1108_FFFF;
    vectors     = 0;
    miscompares = 0;
    clk_en  = 1'b0;
    reset   = 1'b0;
    address = '0;

    test_reset();
    test_sequential();
    test_hold();
    test_unpopulated();
    test_reset_midstream();
    test_repeat();
    test_random();

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
